// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the byte-lane size mask used for stores.
package mem_stage_pkg;

  localparam int MEM_BUS = 64;

  // funct3 access size/sign encodings
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_D  = 3'b011;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [2:0] MEM_WU = 3'b110;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam logic [1:0] ST_OUT  = 2'b11;

  // Unshifted byte-lane enables for an access of the given size
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      MEM_B, MEM_BU: size_mask = 8'h01;
      MEM_H, MEM_HU: size_mask = 8'h03;
      MEM_W, MEM_WU: size_mask = 8'h0F;
      MEM_D:         size_mask = 8'hFF;
      default:       size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_fmt.sv
// Combinational formatting for the memory stage: request address/lane shaping
// and legality check on the incoming op, plus load-beat alignment/extension
// using the size and offset latched when the load was accepted.
module mem_stage_fmt
  import mem_stage_pkg::*;
(
  input  logic [MEM_BUS-1:0] i_addr,
  input  logic [2:0]         i_funct3,
  input  logic               i_mem_rd,
  input  logic               i_mem_wr,
  input  logic [MEM_BUS-1:0] i_wdata,
  input  logic [2:0]         i_ld_funct3,
  input  logic [2:0]         i_ld_sh,
  input  logic [MEM_BUS-1:0] i_rdata,
  output logic [MEM_BUS-1:0] o_req_addr,
  output logic [MEM_BUS-1:0] o_req_wdata,
  output logic [7:0]         o_req_wmask,
  output logic               o_exc,
  output logic [MEM_BUS-1:0] o_ld_data
);

  logic [2:0]         w_sh;
  logic               w_misaligned;
  logic               w_illegal;
  logic [MEM_BUS-1:0] w_ld_shift;

  assign w_sh        = i_addr[2:0];
  assign o_req_addr  = {i_addr[MEM_BUS-1:3], 3'b000};
  assign o_req_wmask = i_mem_wr ? (size_mask(i_funct3) << w_sh) : 8'h00;
  assign o_req_wdata = i_wdata << {w_sh, 3'b000};

  // Natural alignment required for the access size (bytes never misalign)
  always_comb begin
    w_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_addr[0];
      2'b10:   w_misaligned = |i_addr[1:0];
      2'b11:   w_misaligned = |i_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_illegal = (i_mem_rd && i_mem_wr) ||
                     (i_mem_rd && (i_funct3 == 3'b111)) ||
                     (i_mem_wr && i_funct3[2]);
  assign o_exc     = (i_mem_rd || i_mem_wr) && (w_illegal || w_misaligned);

  assign w_ld_shift = i_rdata >> {i_ld_sh, 3'b000};

  // Truncate the lane-aligned beat to the access size, then sign/zero extend
  always_comb begin
    case (i_ld_funct3)
      MEM_B:   o_ld_data = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
      MEM_H:   o_ld_data = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      MEM_W:   o_ld_data = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      MEM_BU:  o_ld_data = {56'd0, w_ld_shift[7:0]};
      MEM_HU:  o_ld_data = {48'd0, w_ld_shift[15:0]};
      MEM_WU:  o_ld_data = {32'd0, w_ld_shift[31:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the RV64 pipeline: FSM, payload registers and the
// execute/memory/writeback handshakes. Non-memory ops take one register stage.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = XLEN / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mem_rd,
  input  logic                 in_mem_wr,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_rd_data,
  input  logic [XLEN-1:0]      in_wdata,
  input  logic [4:0]           in_rd_addr,
  input  logic                 in_rd_wena,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic                 mem_req_wen,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [MEM_BYTES-1:0] mem_req_wmask,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rd_data,
  output logic [4:0]           out_rd_addr,
  output logic                 out_rd_wena,
  output logic                 out_exc
);

  logic [1:0]           r_state;
  logic [XLEN-1:0]      r_req_addr;
  logic [XLEN-1:0]      r_req_wdata;
  logic [MEM_BYTES-1:0] r_req_wmask;
  logic                 r_req_wen;
  logic [2:0]           r_ld_funct3;
  logic [2:0]           r_ld_sh;
  logic                 r_rd_wena;
  logic [XLEN-1:0]      r_out_data;
  logic [4:0]           r_out_addr;
  logic                 r_out_wena;
  logic                 r_out_exc;

  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_in_req;
  logic [XLEN-1:0]      w_req_addr;
  logic [XLEN-1:0]      w_req_wdata;
  logic [MEM_BYTES-1:0] w_req_wmask;
  logic                 w_exc;
  logic [XLEN-1:0]      w_ld_data;

  mem_stage_fmt u_fmt (
    .i_addr      (in_rd_data),
    .i_funct3    (in_funct3),
    .i_mem_rd    (in_mem_rd),
    .i_mem_wr    (in_mem_wr),
    .i_wdata     (in_wdata),
    .i_ld_funct3 (r_ld_funct3),
    .i_ld_sh     (r_ld_sh),
    .i_rdata     (mem_resp_rdata),
    .o_req_addr  (w_req_addr),
    .o_req_wdata (w_req_wdata),
    .o_req_wmask (w_req_wmask),
    .o_exc       (w_exc),
    .o_ld_data   (w_ld_data)
  );

  // in_ready is forced low while reset is held even though the state is IDLE
  assign in_ready = rst && ((r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_is_mem = in_mem_rd || in_mem_wr;
  assign w_in_req = (r_state == ST_REQ);

  assign mem_req_valid = w_in_req;
  assign mem_req_addr  = w_in_req ? r_req_addr  : '0;
  assign mem_req_wen   = w_in_req && r_req_wen;
  assign mem_req_wdata = w_in_req ? r_req_wdata : '0;
  assign mem_req_wmask = w_in_req ? r_req_wmask : '0;

  assign out_valid   = (r_state == ST_OUT);
  assign out_rd_data = r_out_data;
  assign out_rd_addr = r_out_addr;
  assign out_rd_wena = r_out_wena;
  assign out_exc     = r_out_exc;

  // FSM and payload capture; an accept in OUT replaces the handed-off payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wmask <= '0;
      r_req_wen   <= 1'b0;
      r_ld_funct3 <= 3'b000;
      r_ld_sh     <= 3'b000;
      r_rd_wena   <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= 5'd0;
      r_out_wena  <= 1'b0;
      r_out_exc   <= 1'b0;
    end else if (w_accept) begin
      r_req_addr  <= w_req_addr;
      r_req_wdata <= w_req_wdata;
      r_req_wmask <= w_req_wmask;
      r_req_wen   <= in_mem_wr;
      r_ld_funct3 <= in_funct3;
      r_ld_sh     <= in_rd_data[2:0];
      r_rd_wena   <= in_rd_wena && (in_rd_addr != 5'd0) && !in_mem_wr;
      r_out_addr  <= in_rd_addr;
      if (!w_is_mem) begin
        r_state    <= ST_OUT;
        r_out_data <= in_rd_data;
        r_out_wena <= in_rd_wena && (in_rd_addr != 5'd0);
        r_out_exc  <= 1'b0;
      end else if (w_exc) begin
        r_state    <= ST_OUT;
        r_out_data <= '0;
        r_out_wena <= 1'b0;
        r_out_exc  <= 1'b1;
      end else begin
        r_state    <= ST_REQ;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (mem_req_ready) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            r_state    <= ST_OUT;
            r_out_data <= r_req_wen ? '0 : w_ld_data;
            r_out_wena <= r_rd_wena;
            r_out_exc  <= 1'b0;
          end
        end
        ST_OUT: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the stage's results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mem_rd, in_mem_wr, in_rd_wena;
  logic [2:0]  in_funct3;
  logic [63:0] in_rd_data, in_wdata;
  logic [4:0]  in_rd_addr;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_rd_wena, out_exc;
  logic [63:0] out_rd_data;
  logic [4:0]  out_rd_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          exc;
    bit          issue;
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] data;
    bit          wena;
  } exp_t;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_funct3(in_funct3), .in_rd_data(in_rd_data), .in_wdata(in_wdata),
    .in_rd_addr(in_rd_addr), .in_rd_wena(in_rd_wena),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_rd_addr(out_rd_addr), .out_rd_wena(out_rd_wena), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: what the stage must produce for one op, from the access rules
  function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] rdata, input logic [4:0] rda, input bit wena);
    exp_t e;
    int n, sh;
    longint unsigned v;
    bit illegal, mis;
    n  = 1 << f3[1:0];
    sh = int'(a % 8);
    illegal = (rd && wr) || (rd && f3 == 3'd7) || (wr && f3 >= 3'd4);
    mis = (a % n) != 0;
    e = '{default: '0};
    if (!(rd || wr)) begin
      e.data = a;
      e.wena = wena && (rda != 0);
    end else if (illegal || mis) begin
      e.exc = 1'b1;
    end else begin
      e.issue = 1'b1;
      e.addr  = a - 64'(sh);
      e.wen   = wr;
      if (wr) begin
        e.wdata = wd << (8 * sh);
        e.wmask = 8'(((1 << n) - 1) << sh);
      end else begin
        v = rdata >> (8 * sh);
        if (n < 8) begin
          v = v % (64'd1 << (8 * n));
          if (f3 < 3'd4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        end
        e.data = v;
        e.wena = wena && (rda != 0);
      end
    end
    return e;
  endfunction

  task automatic clear_inputs();
    in_valid = 0; in_mem_rd = 0; in_mem_wr = 0; in_funct3 = 0;
    in_rd_data = 0; in_wdata = 0; in_rd_addr = 0; in_rd_wena = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
  endtask

  task automatic resync();
    @(negedge clk);
    clear_inputs();
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  // Drive one op through every handshake with the given stall lengths
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rdata, input logic [4:0] rda,
                        input bit wena, input int req_dly, input int resp_dly, input int out_dly,
                        input string tag);
    exp_t e;
    int err0;
    err0 = errors;
    e = model(rd, wr, f3, a, wd, rdata, rda, wena);
    @(negedge clk);
    in_valid = 1; in_mem_rd = rd; in_mem_wr = wr; in_funct3 = f3;
    in_rd_data = a; in_wdata = wd; in_rd_addr = rda; in_rd_wena = wena;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
    end
    @(negedge clk);
    in_valid = 0; in_rd_data = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
    in_funct3 = 3'($urandom_range(0, 7)); in_rd_addr = 5'($urandom_range(0, 31));
    if (e.issue) begin
      for (int i = 0; i <= req_dly; i++) begin
        mem_req_ready = (i == req_dly);
        mem_resp_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, e.addr, e.wen, e.wmask}) begin
          errors++;
          $display("[TB] FAIL %s req_fields cyc%0d: got v=%b a=%h wen=%b m=%h want v=1 a=%h wen=%b m=%h",
                   tag, i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, e.addr, e.wen, e.wmask);
        end
        if (e.wen) begin
          checks++;
          if (mem_req_wdata !== e.wdata) begin
            errors++; $display("[TB] FAIL %s req_wdata: got %h want %h", tag, mem_req_wdata, e.wdata);
          end
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
          errors++; $display("[TB] FAIL %s busy_in_req: got in_ready=%b out_valid=%b want 0 0", tag, in_ready, out_valid);
        end
        @(negedge clk);
      end
      mem_req_ready = 0;
      for (int i = 0; i <= resp_dly; i++) begin
        mem_resp_valid = (i == resp_dly);
        mem_resp_rdata = (i == resp_dly) ? rdata : {$urandom, $urandom};
        #1;
        checks++;
        if ({mem_req_valid, out_valid, in_ready} !== 3'b000) begin
          errors++; $display("[TB] FAIL %s wait_resp: got req=%b out=%b in_ready=%b want 000", tag, mem_req_valid, out_valid, in_ready);
        end
        @(negedge clk);
      end
      mem_resp_valid = 0; mem_resp_rdata = {$urandom, $urandom};
    end
    for (int i = 0; i <= out_dly; i++) begin
      out_ready = (i == out_dly);
      mem_resp_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({out_valid, out_exc, out_rd_wena, mem_req_valid} !== {1'b1, e.exc, e.wena, 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s out_flags cyc%0d: got v=%b exc=%b wena=%b req=%b want v=1 exc=%b wena=%b req=0",
                 tag, i, out_valid, out_exc, out_rd_wena, mem_req_valid, e.exc, e.wena);
      end
      if (!(e.issue && e.wen)) begin
        checks++;
        if (out_rd_data !== e.data) begin
          errors++; $display("[TB] FAIL %s out_data cyc%0d: got %h want %h", tag, i, out_rd_data, e.data);
        end
      end
      if (!e.exc) begin
        checks++;
        if (out_rd_addr !== rda) begin
          errors++; $display("[TB] FAIL %s out_addr: got %0d want %0d", tag, out_rd_addr, rda);
        end
      end
      checks++;
      if (in_ready !== out_ready) begin
        errors++; $display("[TB] FAIL %s in_ready_out: got %b want %b", tag, in_ready, out_ready);
      end
      @(negedge clk);
    end
    out_ready = 0; mem_resp_valid = 0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL %s back_to_idle: got out_valid=%b in_ready=%b want 0 1", tag, out_valid, in_ready);
    end
    if (errors != err0) resync();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #12;
    checks++;
    if ({in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
         out_valid, out_rd_data, out_rd_addr, out_rd_wena, out_exc} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got nonzero outputs (in_ready=%b out_valid=%b) want all 0", in_ready, out_valid);
    end
    in_valid = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    in_valid = 0; rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d[6];
    logic [4:0]  r[6];
    d[0] = 64'h1234; r[0] = 5'd5;
    for (int k = 1; k < 6; k++) begin
      d[k] = {$urandom, $urandom}; r[k] = 5'($urandom_range(1, 31));
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      out_ready = 1; in_valid = 1; in_mem_rd = 0; in_mem_wr = 0;
      in_rd_data = d[k]; in_rd_addr = r[k]; in_rd_wena = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_in_ready op%0d: got %b want 1", k, in_ready);
      end
      if (k > 0) begin
        checks++;
        if ({out_valid, out_rd_data, out_rd_addr, out_rd_wena, out_exc} !== {1'b1, d[k-1], r[k-1], 1'b1, 1'b0}) begin
          errors++; $display("[TB] FAIL b2b_out op%0d: got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d",
                             k - 1, out_valid, out_rd_data, out_rd_addr, d[k-1], r[k-1]);
        end
      end
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    checks++;
    if ({out_valid, out_rd_data} !== {1'b1, d[5]}) begin
      errors++; $display("[TB] FAIL b2b_last: got v=%b d=%h want v=1 d=%h", out_valid, out_rd_data, d[5]);
    end
    @(negedge clk);
    out_ready = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    run_op(1, 0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 1, 0, 1, 0, "LB");
    run_op(1, 0, 3'b100, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 1, 1, 0, 0, "LBU");
    run_op(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 64'h0, 5'd9, 1, 0, 2, 0, "SH");
    run_op(1, 0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 5'd3, 1, 0, 0, 0, "LW_misaligned");
    run_op(1, 0, 3'b011, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd12, 1, 3, 1, 2, "LD_stall");
    run_op(1, 1, 3'b011, 64'h8000_0010, 64'h0, 64'h0, 5'd12, 1, 0, 0, 0, "rd_and_wr");
    run_op(1, 0, 3'b111, 64'h8000_0010, 64'h0, 64'h0, 5'd12, 1, 0, 0, 0, "load_f3_111");
    run_op(0, 1, 3'b100, 64'h8000_0010, 64'h0, 64'h0, 5'd12, 1, 0, 0, 0, "store_f3_100");
    run_op(1, 0, 3'b010, 64'h8000_0004, 64'h0, 64'hFFFF_FFFF_0000_0000, 5'd0, 1, 0, 0, 1, "LW_rd0");
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid = 1; in_mem_rd = 1; in_mem_wr = 0; in_funct3 = 3'b011;
    in_rd_data = 64'h8000_0040; in_rd_addr = 5'd4; in_rd_wena = 1;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midflight_req: got %b want 1", mem_req_valid);
    end
    @(negedge clk);
    mem_req_ready = 0;
    #1;
    rst = 0;
    #1;
    checks++;
    if ({mem_req_valid, out_valid, in_ready, out_rd_data, out_rd_wena, out_exc} !== '0) begin
      errors++; $display("[TB] FAIL midflight_reset: got req=%b out=%b in_ready=%b want 0 0 0", mem_req_valid, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1; mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midflight_idle_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++;
    if ({out_valid, mem_req_valid, in_ready} !== 3'b001) begin
      errors++; $display("[TB] FAIL stray_resp_ignored: got out=%b req=%b in_ready=%b want 0 0 1", out_valid, mem_req_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1; in_mem_rd = 0; in_rd_data = 64'h55; in_rd_addr = 5'd2;
    @(negedge clk);
    in_valid = 0;
    #1;
    rst = 0;
    #1;
    checks++;
    if ({out_valid, out_rd_data, out_rd_addr} !== '0) begin
      errors++; $display("[TB] FAIL reset_in_out: got v=%b d=%h want 0 0", out_valid, out_rd_data);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [2:0]  f3;
    int kind, sz;
    bit rd, wr;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      rd = (kind >= 3 && kind <= 5) || kind == 9;
      wr = (kind >= 6);
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      run_op(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    $display("[TB] starting mem_stage bench");
    test_reset();
    test_back_to_back();
    test_directed();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage RV64 core.
- Consumes the execute result: for loads and stores, the ALU output is the effective address.
- Issues one aligned 64-bit request per load/store to the data-memory port, aligns and extends load data, and forwards the writeback payload to the writeback stage.
- Non-memory ops pass through with one register stage.

Parameters:
XLEN, 64, datapath width (only 64 supported)
MEM_BYTES, 8, bytes per memory beat (XLEN/8)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  execute-stage payload valid
in_ready  out  1  stage can accept a payload this cycle
in_mem_rd  in  1  op is a load
in_mem_wr  in  1  op is a store
in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
in_rd_data  in  64  execute result (address if load/store)
in_wdata  in  64  store data (rs2)
in_rd_addr  in  5  destination register
in_rd_wena  in  1  destination write enable
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  request address, low 3 bits zero
mem_req_wen  out  1  1 = store, 0 = load
mem_req_wdata  out  64  lane-shifted store data
mem_req_wmask  out  8  byte-lane enables (0 for loads)
mem_resp_valid  in  1  response or store acknowledge
mem_resp_rdata  in  64  raw 64-bit read beat
out_valid  out  1  writeback payload valid
out_ready  in  1  writeback accepts payload
out_rd_data  out  64  result to write back
out_rd_addr  out  5  destination register
out_rd_wena  out  1  write enable
out_exc  out  1  misaligned or illegal access flagged

Behaviour:
- Reset (rst low, asynchronous): state becomes IDLE. All outputs are 0, including in_ready while rst is low. Any in-flight request is abandoned, and a late mem_resp_valid after reset release is ignored in IDLE.
- FSM states: IDLE, REQ, RESP, OUT.
- Accept condition: in_valid && in_ready, where in_ready = (state==IDLE) || (state==OUT && out_ready).
- On accept with no memory op:
  - Latch out_rd_data = in_rd_data and go to OUT. Latency is 1 cycle.
  - Back-to-back throughput is 1 op per cycle when out_ready stays high.
- On accept with a load or store:
  - Latch all inputs.
  - Misaligned address (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0) or load funct3=111 or store funct3[2]=1: go to OUT with out_exc=1, out_rd_wena=0, out_rd_data=0. No memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1, with addr/wen/wdata/wmask held stable until mem_req_ready. Then go to RESP.
- RESP:
  - Wait for mem_resp_valid. Stores also wait for it as an acknowledge.
  - On resp, go to OUT. For loads, latch the extended data.
- OUT:
  - out_valid=1, payload stable until out_ready.
  - If out_ready && in_valid, accept the next op in the same cycle. Otherwise go to IDLE.
- Address and data shaping (sh = addr[2:0]):
  - mem_req_addr = {addr[63:3], 3'b000}.
  - Store: wmask = sizemask << sh, with sizemask B=0x01, H=0x03, W=0x0F, D=0xFF. wdata = in_wdata << (8*sh).
  - Load: r = rdata >> (8*sh). Then truncate to the access size; sign-extend for B/H/W and zero-extend for BU/HU/WU. D passes through.
- out_rd_wena:
  - Forced 0 for stores, exceptions, and rd_addr==0.
  - Otherwise equals the latched in_rd_wena.
- in_mem_rd && in_mem_wr both high: treated as illegal (out_exc=1).
- mem_resp_valid outside RESP is ignored.

Decomposition:
- defines.v additions: funct3 size encodings (MEM_B … MEM_WU), FSM state encodings (2-bit), MEM_BUS width macro.
- One combinational sub-module, mem_stage_fmt, holds mask generation, store lane shift, load shift/extend and the misalignment check.
- mem_stage keeps the FSM, payload registers and handshakes.

Test Plan:
- ALU op, rd_data=0x1234, rd=5, out_ready=1, then a second op next cycle -> out_valid 1 cycle later with 0x1234, rd_wena=1; second op accepted in the OUT cycle (in_ready=1).
- LB addr=0x8000_0003, resp rdata=0x0000_0000_8000_0000 -> mem_req_addr=0x8000_0000, wmask=0, out_rd_data=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- SH addr=0x8000_0006, wdata=0xABCD -> wmask=0xC0, mem_req_wdata=0xABCD_0000_0000_0000, wen=1; after ack out_rd_wena=0.
- LW addr=0x8000_0002 -> no mem_req_valid ever, out_exc=1, out_rd_wena=0, out_valid next cycle.
- LD with mem_req_ready low 3 cycles and out_ready low 2 cycles -> req fields stable for all 4 cycles, out payload stable, in_ready=0 throughout.
- rst low during RESP -> out_valid/mem_req_valid 0 immediately; stray mem_resp_valid after release ignored; in_ready=1 in IDLE.
